// File: rtl/score_pkg.sv
// Shared widths, FSM state type and 7-segment decode for the score display.
package score_pkg;

  localparam int unsigned SCORE_W     = 14;
  localparam int unsigned MAX_SCORE   = 9999;
  localparam int unsigned BCD_DIGITS  = 4;
  localparam int unsigned BCD_W       = 4 * BCD_DIGITS;
  localparam int unsigned SEG_W       = 7;
  localparam int unsigned SHIFT_STEPS = SCORE_W;
  localparam int unsigned STEP_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Active-high segments ordered {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  // Decimal-only decode; codes 10-15 render dark
  function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Clamp a raw score to the four-digit display range
  function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] s);
    return (s > SCORE_W'(MAX_SCORE)) ? SCORE_W'(MAX_SCORE) : s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter with a one-deep latest-value pending slot.
module bin2bcd_seq
  import score_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SCORE_W-1:0] score_i,
  input  logic               valid_i,
  output logic [BCD_W-1:0]   bcd_o,
  output logic               busy_o,
  output logic               done_o
);

  state_e              state_q;
  logic [SCORE_W-1:0]  bin_q, bin_d;
  logic [BCD_W-1:0]    work_q, work_d, adj_c;
  logic [STEP_W-1:0]   step_q;
  logic                pend_vld_q;
  logic [SCORE_W-1:0]  pend_val_q;
  logic [BCD_W-1:0]    bcd_q;
  logic                busy_q, done_q;

  // One add-3-then-shift iteration over the BCD accumulator and binary source
  always_comb begin
    adj_c = work_q;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (adj_c[4*i +: 4] >= 4'd5) adj_c[4*i +: 4] = adj_c[4*i +: 4] + 4'd3;
    end
    work_d = {adj_c[BCD_W-2:0], bin_q[SCORE_W-1]};
    bin_d  = {bin_q[SCORE_W-2:0], 1'b0};
  end

  // Conversion FSM; bcd_q only loads on entry to DONE so no partial result escapes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bin_q      <= '0;
      work_q     <= '0;
      step_q     <= '0;
      pend_vld_q <= 1'b0;
      pend_val_q <= '0;
      bcd_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pend_vld_q) begin
            bin_q      <= sat_score(pend_val_q);
            work_q     <= '0;
            step_q     <= '0;
            busy_q     <= 1'b1;
            state_q    <= ST_SHIFT;
            pend_vld_q <= valid_i;
            if (valid_i) pend_val_q <= score_i;
          end else if (valid_i) begin
            bin_q   <= sat_score(score_i);
            work_q  <= '0;
            step_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          work_q <= work_d;
          bin_q  <= bin_d;
          step_q <= step_q + STEP_W'(1);
          if (step_q == STEP_W'(SHIFT_STEPS - 1)) begin
            bcd_q   <= work_d;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
          if (valid_i) begin
            pend_vld_q <= 1'b1;
            pend_val_q <= score_i;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
          if (valid_i) begin
            pend_vld_q <= 1'b1;
            pend_val_q <= score_i;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bcd_o  = bcd_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: rtl/score_bcd_display.sv
// Score to BCD conversion plus multiplexed 4-digit 7-segment drive.
module score_bcd_display
  import score_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 1024,
  parameter int unsigned BLANK_LZ    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SCORE_W-1:0] score,
  input  logic               score_valid,
  output logic [BCD_W-1:0]   bcd_out,
  output logic [SEG_W-1:0]   seg,
  output logic [3:0]         digit_sel,
  output logic               busy,
  output logic               done
);

  localparam int unsigned REF_W = $clog2(REFRESH_DIV);

  logic [REF_W-1:0] ref_q, ref_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       sel_q, sel_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [3:0]       digit_c;
  logic             blank_c;

  bin2bcd_seq u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .score_i (score),
    .valid_i (score_valid),
    .bcd_o   (bcd_out),
    .busy_o  (busy),
    .done_o  (done)
  );

  // Refresh divider, digit rotation and next segment pattern with leading-zero blanking
  always_comb begin
    ref_d = ref_q + REF_W'(1);
    idx_d = idx_q;
    if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      idx_d = idx_q + 2'd1;
    end
    sel_d = 4'b0001 << idx_d;
    case (idx_d)
      2'd0:    begin digit_c = bcd_out[3:0];   blank_c = 1'b0;                 end
      2'd1:    begin digit_c = bcd_out[7:4];   blank_c = (bcd_out[15:4] == '0); end
      2'd2:    begin digit_c = bcd_out[11:8];  blank_c = (bcd_out[15:8] == '0); end
      default: begin digit_c = bcd_out[15:12]; blank_c = (bcd_out[15:12] == '0); end
    endcase
    seg_d = ((BLANK_LZ != 0) && blank_c) ? SEG_BLANK : seg_decode(digit_c);
  end

  // seg and digit_sel register together so they always switch on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_q <= '0;
      idx_q <= '0;
      sel_q <= 4'b0001;
      seg_q <= SEG_0;
    end else begin
      ref_q <= ref_d;
      idx_q <= idx_d;
      sel_q <= sel_d;
      seg_q <= seg_d;
    end
  end

  assign digit_sel = sel_q;
  assign seg       = seg_q;

endmodule

// File: tb/tb_score_bcd_display.sv
// Scoreboard bench for score_bcd_display with a cycle-count reference model.
module tb_score_bcd_display;

  localparam int unsigned DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] score = '0;
  logic        score_valid = 1'b0;
  logic [15:0] bcd_out;
  logic [6:0]  seg;
  logic [3:0]  digit_sel;
  logic        busy, done;

  always #5 clk = ~clk;

  score_bcd_display #(.REFRESH_DIV(DIV), .BLANK_LZ(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .score       (score),
    .score_valid (score_valid),
    .bcd_out     (bcd_out),
    .seg         (seg),
    .digit_sel   (digit_sel),
    .busy        (busy),
    .done        (done)
  );

  typedef struct {
    logic [15:0] bcd;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  int unsigned cyc = 0, edges = 0, free_cyc = 0, load_cyc = 0;
  int unsigned busy_from = 1, busy_to = 0;
  bit          load_pend = 0, pend_v = 0;
  logic [15:0] load_val = '0, model_bcd = '0;
  logic [13:0] pend_s = '0;
  logic [3:0]  exp_sel = 4'b0001;
  logic [6:0]  exp_seg = 7'h3F;

  logic [6:0] segt [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic void chk(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endfunction

  function automatic logic [15:0] to_bcd(input int unsigned v);
    int unsigned s;
    s = (v > 9999) ? 9999 : v;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic logic [6:0] seg_of(input logic [15:0] b, input int unsigned idx);
    logic [15:0] hi;
    logic [3:0]  d;
    hi = b >> (4 * idx);
    d  = hi[3:0];
    if (idx != 0 && hi == 16'h0) return 7'h00;
    if (d > 4'd9) return 7'h00;
    return segt[d];
  endfunction

  task automatic start_conv(input logic [13:0] s);
    exp_t e;
    e.bcd = to_bcd(int'(s));
    e.cyc = cyc + 15;
    exp_q.push_back(e);
    load_val  = e.bcd;
    load_cyc  = cyc + 14;
    load_pend = 1;
    free_cyc  = cyc + 16;
    busy_from = cyc + 1;
    busy_to   = cyc + 15;
  endtask

  // Reference model: decides acceptance per edge from time bookkeeping
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      cyc = 0; edges = 0; free_cyc = 0; load_pend = 0; pend_v = 0;
      model_bcd = '0; busy_from = 1; busy_to = 0;
      exp_sel = 4'b0001; exp_seg = 7'h3F;
      exp_q.delete();
    end else begin
      edges++;
      exp_sel = 4'(1 << ((edges / DIV) % 4));
      exp_seg = seg_of(model_bcd, (edges / DIV) % 4);
      if (load_pend && cyc == load_cyc) begin
        model_bcd = load_val;
        load_pend = 0;
      end
      if (cyc >= free_cyc) begin
        if (pend_v) begin
          start_conv(pend_s);
          pend_v = score_valid;
          pend_s = score;
        end else if (score_valid) begin
          start_conv(score);
        end
      end else if (score_valid) begin
        pend_v = 1;
        pend_s = score;
      end
      cyc++;
    end
  end

  // Monitor: compares outputs on the falling edge and pops the scoreboard on done
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("busy", busy, (cyc >= busy_from && cyc <= busy_to) ? 1 : 0);
      chk("bcd_out_hold", bcd_out, model_bcd);
      chk("digit_sel", digit_sel, exp_sel);
      chk("seg", seg, exp_seg);
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_bcd", bcd_out, e.bcd);
          chk("done_cycle", cyc, e.cyc);
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        chk("missing_done", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [13:0] v);
    score = v;
    score_valid = 1'b1;
    @(posedge clk);
    #1;
    score_valid = 1'b0;
  endtask

  initial begin
    wait_cyc(3);
    rst_n = 1'b1;
    // first edge after reset release accepts immediately
    strobe(14'd1234);
    wait_cyc(25);
    strobe(14'd12000);
    wait_cyc(20);
    strobe(14'd0);
    wait_cyc(25);
    // latest-value pending slot: 57 is overwritten by 88
    strobe(14'd42);
    wait_cyc(2);
    strobe(14'd57);
    wait_cyc(2);
    strobe(14'd88);
    wait_cyc(40);
    // strobe landing exactly on the DONE cycle
    strobe(14'd1234);
    wait_cyc(14);
    strobe(14'd777);
    wait_cyc(40);
    // blanked display pattern 5,0,3,blank
    strobe(14'd305);
    wait_cyc(40);
    // reset during SHIFT cycle 7
    strobe(14'd4321);
    wait_cyc(6);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bcd", bcd_out, 0);
    chk("rst_sel", digit_sel, 4'b0001);
    chk("rst_seg", seg, 7'h3F);
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(30);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        score = ($urandom_range(0, 1) == 0) ? 14'($urandom_range(0, 9999))
                                            : 14'($urandom_range(0, 16383));
        score_valid = 1'b1;
      end else begin
        score_valid = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    score_valid = 1'b0;
    wait_cyc(40);
    chk("drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
